bcd_xs3_converter: RTL and testbench
====================================

# bcd_xs3_converter

Multi-digit, bidirectional BCD / Excess-3 code converter with a valid/ready handshake on both sides. It accepts a packed word of `DIGITS` 4-bit digits and converts it iteratively, one digit per clock, least-significant digit first. It flags any digit that is illegal in the source code. It is the parametrised, sequential successor of the single-digit combinational BCD-to-Excess-3 converter and sits between the BCD counter/display datapaths in the lab designs.

## Interface
- `DIGITS`, default 4: number of 4-bit digits per word; legal range 1..16.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in_valid` in 1: `in_data`/`mode` valid.
- `in_ready` out 1: converter can accept a word.
- `in_data` in 4*DIGITS: packed source digits; digit i is `[4i+3:4i]`.
- `mode` in 1: 0 = BCD→XS3, 1 = XS3→BCD; sampled only at acceptance.
- `out_valid` out 1: `out_data`/`err` valid.
- `out_ready` in 1: consumer takes the result.
- `out_data` out 4*DIGITS: converted digits, same packing as `in_data`.
- `err` out 1: at least one source digit was illegal.

## Operation
- FSM states are IDLE, CONV and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `in_data` into the source register and `mode` into the mode register; clear the result register, `err` and the digit index; go to CONV.
- **CONV**
  - `in_ready`=0.
  - Each cycle, convert source digit[idx] through the digit converter, write it into result digit[idx] and OR its illegal flag into `err`; then increment idx.
  - After the cycle with idx = DIGITS-1, go to DONE.
- **DONE**
  - `out_valid`=1; `out_data` and `err` are held stable.
  - On `out_valid & out_ready`: go to IDLE. `in_ready` stays 0 in DONE, so a word cannot be accepted in the same cycle as the output handshake.
- **Digit rules**
  - BCD→XS3: legal inputs are 0..9; output = d+3 (4-bit).
  - XS3→BCD: legal inputs are 3..12; output = d−3 (4-bit).
  - An illegal digit produces output digit 4'h0 and sets `err`. The remaining digits are still converted normally.
- Input changes on `mode` or `in_data` outside acceptance are ignored.
- Index counter width is max(1, $clog2(DIGITS)).
- When DIGITS=1, CONV lasts exactly one cycle.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=1 once reset deasserts (0 while `reset`=1).
  - `out_valid`=0, `out_data`=0, `err`=0, idx=0.
- Latency: for acceptance at rising edge k, `out_valid` rises after edge k+DIGITS.
- Throughput: one word per DIGITS+2 cycles with `out_ready` tied high.
- Backpressure: `out_valid` stays high and outputs hold for any number of cycles while `out_ready`=0.
- Reset mid-operation (CONV or DONE): the partial word is discarded and all outputs return to their reset values asynchronously. No output handshake occurs for that word.
- `out_ready` asserted in IDLE or CONV has no effect.

## Structure
- Package `bcd_xs3_pkg`:
  - state enum `{IDLE, CONV, DONE}`.
  - mode constants `MODE_BCD2XS3`=1'b0 and `MODE_XS32BCD`=1'b1.
  - `XS3_OFFSET`=4'd3.
  - legal-range bounds BCD_MAX=9, XS3_MIN=3, XS3_MAX=12.
- Sub-module `xs3_digit_conv`: purely combinational. Inputs are a 4-bit digit and `mode`; outputs are the 4-bit converted digit and an `illegal` flag. Instantiated once and shared across digits via idx muxing.
- Top level holds the FSM, idx counter, source/result registers and the `err` accumulator.

## Test plan
- **Reset**: assert `reset` mid-idle and release → `in_ready`=1, `out_valid`=0, `out_data`=0, `err`=0.
- **BCD→XS3, DIGITS=4**: `in_data`=16'h1239, `mode`=0 → after 4 cycles `out_data`=16'h456C, `err`=0; `out_valid` held until `out_ready`.
- **XS3→BCD round trip**: `in_data`=16'h456C, `mode`=1 → `out_data`=16'h1239, `err`=0.
- **Illegal digits**:
  - `in_data`=16'h12A4, `mode`=0 → `out_data`=16'h4507, `err`=1.
  - `in_data`=16'h3D24, `mode`=1 → `out_data`=16'h0A00? No: digits 3→0, D illegal→0, 2 illegal→0, 4→1, so `out_data`=16'h0001, `err`=1.
- **Backpressure and reset abort**:
  - Hold `out_ready`=0 for 5 cycles in DONE → outputs stable; `in_valid` is ignored throughout.
  - Pulse `reset` during CONV → immediate return to IDLE with no `out_valid`.
- **Exhaustive single digit, DIGITS=1**: sweep 0..15 in both modes → outputs and `err` match the digit rules; latency is exactly 1 cycle. Also run back-to-back words with `out_ready`=1 and confirm the DIGITS+2 cycle spacing.

Source files
------------

// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the iterative BCD / Excess-3 converter.
package bcd_xs3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic       MODE_BCD2XS3 = 1'b0;
    localparam logic       MODE_XS32BCD = 1'b1;
    localparam logic [3:0] XS3_OFFSET   = 4'd3;
    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] XS3_MIN      = 4'd3;
    localparam logic [3:0] XS3_MAX      = 4'd12;

endpackage

// File: rtl/xs3_digit_conv.sv
// Combinational single-digit BCD <-> Excess-3 converter with illegal-code flag.
module xs3_digit_conv
    import bcd_xs3_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       mode,
    output logic [3:0] result,
    output logic       illegal
);

    always_comb begin
        result  = 4'h0;
        illegal = 1'b0;
        if (mode == MODE_BCD2XS3) begin
            if (digit <= BCD_MAX) result = digit + XS3_OFFSET;
            else                  illegal = 1'b1;
        end else begin
            if (digit >= XS3_MIN && digit <= XS3_MAX) result = digit - XS3_OFFSET;
            else                                      illegal = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_xs3_converter.sv
// Multi-digit BCD <-> Excess-3 converter: one digit per clock, LSD first,
// valid/ready on both sides, sticky error flag for illegal source digits.
module bcd_xs3_converter
    import bcd_xs3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  err,
    output logic [1:0]            state_dbg
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Handshake rule: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready, and a presented word is held.
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W+1:0]     bit_base;
    logic [4*DIGITS-1:0]  src_q;
    logic [4*DIGITS-1:0]  res_q;
    logic                 mode_q;
    logic                 err_q;
    logic                 accept;
    logic                 last_digit;
    logic [3:0]           cur_digit;
    logic [3:0]           conv_digit;
    logic                 conv_illegal;

    assign bit_base   = {idx_q, 2'b00};
    assign cur_digit  = src_q[bit_base +: 4];
    assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

    xs3_digit_conv u_digit_conv (
        .digit   (cur_digit),
        .mode    (mode_q),
        .result  (conv_digit),
        .illegal (conv_illegal)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                // Forced low during reset so no word is taken while clearing.
                in_ready = ~reset;
                accept   = in_valid & ~reset;
                if (accept) state_d = CONV;
            end
            CONV: begin
                if (last_digit) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
            mode_q  <= MODE_BCD2XS3;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src_q  <= in_data;
                mode_q <= mode;
                res_q  <= '0;
                err_q  <= 1'b0;
                idx_q  <= '0;
            end else if (state_q == CONV) begin
                res_q[bit_base +: 4] <= conv_digit;
                err_q                <= err_q | conv_illegal;
                idx_q                <= last_digit ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign out_data  = res_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_xs3_converter.sv
// Directed bench for bcd_xs3_converter: a 4-digit and a 1-digit instance.
module tb_bcd_xs3_converter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-digit instance
    logic        iv4, ir4, m4, ov4, or4, e4;
    logic [15:0] id4, od4;
    logic [1:0]  st4;
    // 1-digit instance
    logic        iv1, ir1, m1, ov1, or1, e1;
    logic [3:0]  id1, od1;
    logic [1:0]  st1;

    bcd_xs3_converter #(.DIGITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .mode(m4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .err(e4),
        .state_dbg(st4)
    );

    bcd_xs3_converter #(.DIGITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .mode(m1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .err(e1),
        .state_dbg(st1)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];

    // Hand-computed single-digit tables, index = source digit.
    logic [3:0]  b2x_tbl [16] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA,
                                  4'hB, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  x2b_tbl [16] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                                  4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'h0, 4'h0, 4'h0};
    logic [15:0] b2x_err = 16'hFC00;
    logic [15:0] x2b_err = 16'hE007;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [15:0] data, input logic md,
                         input logic [15:0] exp_data, input logic exp_e);
        int cyc;
        logic [16:0] exp;
        exp_q.push_back({exp_e, exp_data});
        iv4 = 1'b1; id4 = data; m4 = md;
        tick();
        iv4 = 1'b0; id4 = 16'($urandom); m4 = ~md;
        cyc = 0;
        while (!ov4 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("lat4", 64'(cyc), 64'd4);
        exp = exp_q.pop_front();
        check("data4", 64'(od4), 64'(exp[15:0]));
        check("err4", 64'(e4), 64'(exp[16]));
        or4 = 1'b1;
        tick();
        or4 = 1'b0;
        check("ack4", 64'(ov4), 64'd0);
    endtask

    task automatic send1(input logic [3:0] data, input logic md,
                         input logic [3:0] exp_data, input logic exp_e);
        int cyc;
        iv1 = 1'b1; id1 = data; m1 = md;
        tick();
        iv1 = 1'b0; id1 = ~data; m1 = ~md;
        cyc = 0;
        while (!ov1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("lat1", 64'(cyc), 64'd1);
        check("data1", 64'(od1), 64'(exp_data));
        check("err1", 64'(e1), 64'(exp_e));
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
    endtask

    initial begin
        int cyc;
        int last_acc;
        logic seen;
        reset = 1'b1;
        iv4 = 1'b0; id4 = '0; m4 = 1'b0; or4 = 1'b0;
        iv1 = 1'b0; id1 = '0; m1 = 1'b0; or1 = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_in_ready_low", 64'(ir4), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(ir4), 64'd1);
        check("rst_out_valid", 64'(ov4), 64'd0);
        check("rst_out_data", 64'(od4), 64'd0);
        check("rst_err", 64'(e4), 64'd0);
        check("rst_in_ready1", 64'(ir1), 64'd1);
        tick();

        // Directed 4-digit vectors
        send4(16'h1239, 1'b0, 16'h456C, 1'b0);
        send4(16'h456C, 1'b1, 16'h1239, 1'b0);
        send4(16'h12A4, 1'b0, 16'h4507, 1'b1);
        send4(16'h3D24, 1'b1, 16'h0001, 1'b1);

        // Backpressure: 0987 -> 3CBA, held while out_ready is low
        iv4 = 1'b1; id4 = 16'h0987; m4 = 1'b0;
        tick();
        id4 = 16'h1111;
        cyc = 0;
        while (!ov4 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("bp_lat", 64'(cyc), 64'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 64'(ov4), 64'd1);
            check("bp_data", 64'(od4), 64'h3CBA);
            check("bp_in_ready", 64'(ir4), 64'd0);
        end
        check("bp_err", 64'(e4), 64'd0);
        or4 = 1'b1;
        tick();
        check("hs_valid_drop", 64'(ov4), 64'd0);
        check("hs_state_idle", 64'(st4), 64'd0);
        iv4 = 1'b0; or4 = 1'b0;
        tick();
        check("hs_no_accept", 64'(st4), 64'd0);

        // Reset abort in CONV after an illegal digit set err
        iv4 = 1'b1; id4 = 16'h12A4; m4 = 1'b0;
        tick();
        iv4 = 1'b0;
        tick();
        tick();
        check("abort_partial", 64'(od4), 64'h0007);
        check("abort_err_pre", 64'(e4), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_out_valid", 64'(ov4), 64'd0);
        check("abort_out_data", 64'(od4), 64'd0);
        check("abort_err", 64'(e4), 64'd0);
        check("abort_in_ready", 64'(ir4), 64'd0);
        reset = 1'b0;
        #1;
        check("abort_idle", 64'(ir4), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov4) seen = 1'b1;
        end
        check("abort_no_output", 64'(seen), 64'd0);

        // Exhaustive single digit, both modes
        for (int d = 0; d < 16; d++)
            send1(4'(d), 1'b0, b2x_tbl[d], b2x_err[d]);
        for (int d = 0; d < 16; d++)
            send1(4'(d), 1'b1, x2b_tbl[d], x2b_err[d]);

        // Back-to-back words, out_ready tied high: one accept every 3 cycles
        iv1 = 1'b1; id1 = 4'h2; m1 = 1'b0; or1 = 1'b1;
        last_acc = -1;
        for (int c = 0; c < 13; c++) begin
            if (ir1) begin
                if (last_acc >= 0) check("b2b_spacing", 64'(c - last_acc), 64'd3);
                last_acc = c;
            end
            if (ov1) check("b2b_data", 64'(od1), 64'h5);
            tick();
        end
        iv1 = 1'b0;
        cyc = 0;
        while (!ir1 && cyc < 10) begin
            tick();
            cyc++;
        end
        or1 = 1'b0;
        check("b2b_drain", 64'(ir1), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
